// File: rtl/wb_stage.sv
// Writeback stage: buffers cache-stage results in a FIFO and retires one per cycle into the RF write port.
// Define WB_FORWARD_EN to build the in-flight result forwarding lookup; otherwise fwd_hit/fwd_data are 0.
module wb_stage #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        c_ready,
    input  logic [31:0] cw_pc,
    input  logic [4:0]  cw_write_sel,
    input  logic [31:0] cw_result,
    input  logic        cw_is_wb,
    output logic        w_ready,
    input  logic        rf_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wr_valid,
    output logic [31:0] wr_pc,
    output logic [31:0] retire_count,
    input  logic [4:0]  fwd_sel,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  sel;
        logic [31:0] result;
        logic        is_wb;
    } entry_t;

    entry_t        mem_q [DEPTH];
    ptr_t          rd_ptr_q, rd_ptr_d;
    ptr_t          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          wr_valid_q, wr_valid_d;
    logic [31:0]   wr_pc_q, wr_pc_d;
    logic [31:0]   retire_cnt_q, retire_cnt_d;

    logic   push, pop;
    entry_t head;

    assign push = c_ready;
    assign pop  = (count_q != '0) && !rf_busy;
    assign head = mem_q[rd_ptr_q];

    // Threshold at DEPTH-1 leaves room for the item already in flight when w_ready falls.
    assign w_ready = !reset && (count_q < CW'(DEPTH - 1));

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        rf_we_d      = 1'b0;
        wr_valid_d   = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        wr_pc_d      = wr_pc_q;
        retire_cnt_d = retire_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            wr_valid_d   = 1'b1;
            wr_pc_d      = head.pc;
            rf_we_d      = head.is_wb && (head.sel != 5'd0);
            rf_waddr_d   = head.sel;
            rf_wdata_d   = head.result;
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            wr_valid_q   <= 1'b0;
            wr_pc_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            wr_valid_q   <= wr_valid_d;
            wr_pc_q      <= wr_pc_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= '{pc: cw_pc, sel: cw_write_sel, result: cw_result, is_wb: cw_is_wb};
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign wr_valid     = wr_valid_q;
    assign wr_pc        = wr_pc_q;
    assign retire_count = retire_cnt_q;

`ifdef WB_FORWARD_EN
    ptr_t idx;

    // Scan oldest to youngest so the last match (youngest) wins; the RF stage seeds the lowest priority.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = rd_ptr_q;
        if (fwd_sel != 5'd0) begin
            if (rf_we_q && (rf_waddr_q == fwd_sel)) begin
                fwd_hit  = 1'b1;
                fwd_data = rf_wdata_q;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if ((CW'(i) < count_q) && mem_q[idx].is_wb && (mem_q[idx].sel == fwd_sel)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = mem_q[idx].result;
                end
            end
        end
    end
`else
    logic unused_fwd_sel;
    assign unused_fwd_sel = ^fwd_sel;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a queue-based model.
module tb_wb_stage;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        c_ready;
    logic [31:0] cw_pc;
    logic [4:0]  cw_write_sel;
    logic [31:0] cw_result;
    logic        cw_is_wb;
    logic        w_ready;
    logic        rf_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wr_valid;
    logic [31:0] wr_pc;
    logic [31:0] retire_count;
    logic [4:0]  fwd_sel;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    wb_stage #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .c_ready      (c_ready),
        .cw_pc        (cw_pc),
        .cw_write_sel (cw_write_sel),
        .cw_result    (cw_result),
        .cw_is_wb     (cw_is_wb),
        .w_ready      (w_ready),
        .rf_busy      (rf_busy),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .wr_valid     (wr_valid),
        .wr_pc        (wr_pc),
        .retire_count (retire_count),
        .fwd_sel      (fwd_sel),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  sel;
        logic [31:0] res;
        logic        wb;
    } item_t;

    item_t       q[$];
    logic        m_we, m_valid;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_pc, m_rc;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic        last_wready = 1'b0;
    int unsigned pulses;
    int unsigned pushes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 1'b0; m_valid = 1'b0; m_waddr = '0; m_wdata = '0; m_pc = '0; m_rc = '0;
    endtask

    // One clock: apply inputs, check combinational outputs, advance model, check registered outputs.
    task automatic do_cycle(input logic rst, input logic c, input logic [31:0] pc, input logic [4:0] sel,
                            input logic [31:0] res, input logic wb, input logic busy, input logic [4:0] fs);
        logic        e_hit;
        logic [31:0] e_data;
        item_t       h;
        reset = rst; c_ready = c; cw_pc = pc; cw_write_sel = sel; cw_result = res;
        cw_is_wb = wb; rf_busy = busy; fwd_sel = fs;
        #2;
        e_hit = 1'b0; e_data = '0;
`ifdef WB_FORWARD_EN
        if (fs != 5'd0) begin
            if (m_we && m_waddr == fs) begin e_hit = 1'b1; e_data = m_wdata; end
            for (int k = 0; k < q.size(); k++)
                if (q[k].wb && q[k].sel == fs) begin e_hit = 1'b1; e_data = q[k].res; end
        end
`endif
        check("w_ready", 32'(w_ready), 32'(!rst && (q.size() < DEPTH - 1)));
        check("fwd_hit", 32'(fwd_hit), 32'(e_hit));
        check("fwd_data", fwd_data, e_data);
        last_wready = w_ready;
        if (rst) begin
            model_reset();
        end else begin
            if (c && q.size() >= DEPTH) check("push_overflow", 32'(q.size()), DEPTH - 1);
            if (q.size() > 0 && !busy) begin
                h = q.pop_front();
                m_valid = 1'b1; m_pc = h.pc; m_we = h.wb && (h.sel != 5'd0);
                m_waddr = h.sel; m_wdata = h.res; m_rc = m_rc + 32'd1;
            end else begin
                m_valid = 1'b0; m_we = 1'b0;
            end
            if (c) q.push_back('{pc: pc, sel: sel, res: res, wb: wb});
        end
        @(posedge clock);
        #1;
        check("wr_valid", 32'(wr_valid), 32'(m_valid));
        check("rf_we", 32'(rf_we), 32'(m_we));
        check("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        check("rf_wdata", rf_wdata, m_wdata);
        check("wr_pc", wr_pc, m_pc);
        check("retire_count", retire_count, m_rc);
        if (wr_valid) pulses++;
    endtask

    task automatic idle(input logic busy, input logic [4:0] fs);
        do_cycle(1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, busy, fs);
    endtask

    task automatic push1(input logic [31:0] pc, input logic [4:0] sel, input logic [31:0] res,
                         input logic wb, input logic busy);
        do_cycle(1'b0, 1'b1, pc, sel, res, wb, busy, 5'd0);
    endtask

    task automatic rst_cycle();
        do_cycle(1'b1, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        reset = 1'b1; c_ready = 1'b0; cw_pc = '0; cw_write_sel = '0; cw_result = '0;
        cw_is_wb = 1'b0; rf_busy = 1'b0; fwd_sel = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        rst_cycle();

        // single item
        push1(32'h100, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
        idle(1'b0, 5'd0);
        check("t1_rf_we", 32'(rf_we), 32'd1);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        check("t1_rc", retire_count, 32'd1);
        idle(1'b0, 5'd0);

        // x0 and non-writeback items
        push1(32'h104, 5'd0, 32'h1234, 1'b1, 1'b0);
        push1(32'h108, 5'd7, 32'h5678, 1'b0, 1'b0);
        check("t2_x0_rf_we", 32'(rf_we), 32'd0);
        idle(1'b0, 5'd0);
        check("t2_nowb_rf_we", 32'(rf_we), 32'd0);
        check("t2_rc", retire_count, 32'd3);

        // backpressure: upstream pulses one cycle after w_ready
        rst_cycle();
        pushes = 0;
        for (int k = 0; k < 8; k++) begin
            if (last_wready) pushes++;
            do_cycle(1'b0, last_wready, 32'h200 + 32'(k), 5'(k + 1), 32'hA0 + 32'(k), 1'b1, 1'b1, 5'd0);
        end
        check("bp_accepted", pushes, 32'd4);
        pulses = 0;
        for (int k = 0; k < 4; k++) idle(1'b0, 5'd0);
        check("bp_retired", pulses, 32'd4);
        idle(1'b0, 5'd0);

        // forwarding
        rst_cycle();
        push1(32'h300, 5'd3, 32'h11, 1'b1, 1'b1);
        push1(32'h304, 5'd3, 32'h22, 1'b1, 1'b1);
        idle(1'b1, 5'd3);
`ifdef WB_FORWARD_EN
        check("fwd_youngest", fwd_data, 32'h22);
`else
        check("fwd_disabled", 32'(fwd_hit), 32'd0);
`endif
        idle(1'b1, 5'd0);
        idle(1'b1, 5'd9);
        idle(1'b0, 5'd3);
        idle(1'b0, 5'd3);
        idle(1'b0, 5'd3);

        // counter wrap via hierarchical deposit
        dut.retire_cnt_q = 32'hFFFFFFFF;
        m_rc = 32'hFFFFFFFF;
        push1(32'h400, 5'd1, 32'h1, 1'b1, 1'b0);
        idle(1'b0, 5'd0);
        check("wrap_rc", retire_count, 32'd0);

        // reset mid-operation with 3 items buffered
        push1(32'h500, 5'd2, 32'h2, 1'b1, 1'b1);
        push1(32'h504, 5'd3, 32'h3, 1'b1, 1'b1);
        push1(32'h508, 5'd4, 32'h4, 1'b1, 1'b1);
        rst_cycle();
        pulses = 0;
        for (int k = 0; k < 3; k++) idle(1'b0, 5'd0);
        check("rst_no_retire", pulses, 32'd0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            do_cycle(1'b0, last_wready && ($urandom_range(0, 3) != 0), $urandom(),
                     5'($urandom_range(0, 7)), $urandom(), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)));
        end
        for (int k = 0; k < 6; k++) idle(1'b0, 5'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
